// File: rtl/pinball_round_ctrl.sv
// Round controller for VGA pinball: detects the ball falling past the floor,
// emits a fixed-width lose pulse, then holds the ball at spawn for a number of frames.
module pinball_round_ctrl #(
    parameter int FLOOR_Y        = 470,
    parameter int LOSE_HOLD      = 4,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [9:0] ball_y,
    input  logic       launch,
    output logic       lose,
    output logic       ball_rst,
    output logic       in_play,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        MISS    = 2'd2,
        RESPAWN = 2'd3
    } state_t;

    localparam logic [9:0] FLOOR      = 10'(FLOOR_Y);
    localparam logic [7:0] HOLD_LOAD  = 8'(LOSE_HOLD - 1);
    localparam logic [7:0] FRAME_LOAD = 8'(RESPAWN_FRAMES);

    state_t     cur_state;
    state_t     nxt_state;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       launch_rise;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic [7:0] frame_cnt;
    logic [7:0] frame_nxt;

    // s1/s2 resynchronise the button; s3 delays s2 so a held button gives one rise.
    assign launch_rise = s2 & ~s3;
    assign state       = cur_state;

    always_comb begin
        nxt_state = cur_state;
        hold_nxt  = hold_cnt;
        frame_nxt = frame_cnt;
        case (cur_state)
            IDLE: begin
                if (launch_rise) begin
                    nxt_state = PLAY;
                end
            end
            PLAY: begin
                if (frame_tick && (ball_y >= FLOOR)) begin
                    nxt_state = MISS;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            MISS: begin
                if (hold_cnt == 8'd0) begin
                    nxt_state = RESPAWN;
                    frame_nxt = FRAME_LOAD;
                end else begin
                    hold_nxt = hold_cnt - 8'd1;
                end
            end
            RESPAWN: begin
                // Exit is tested before decrementing so the counter can never wrap.
                if (frame_tick) begin
                    if (frame_cnt <= 8'd1) begin
                        nxt_state = IDLE;
                    end else begin
                        frame_nxt = frame_cnt - 8'd1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            hold_cnt  <= 8'd0;
            frame_cnt <= 8'd0;
            lose      <= 1'b0;
            ball_rst  <= 1'b1;
            in_play   <= 1'b0;
        end else begin
            s1        <= launch;
            s2        <= s1;
            s3        <= s2;
            cur_state <= nxt_state;
            hold_cnt  <= hold_nxt;
            frame_cnt <= frame_nxt;
            // Outputs are decoded from the next state so they change with the state.
            lose      <= (nxt_state == MISS);
            ball_rst  <= (nxt_state != PLAY);
            in_play   <= (nxt_state == PLAY);
        end
    end

endmodule

// File: tb/tb_pinball_round_ctrl.sv
// Cycle-level bench for pinball_round_ctrl: a vector table for the main round,
// then hand-written sequences for held launch, ignored inputs and mid-miss reset.
module tb_pinball_round_ctrl;

    localparam int FLOOR_Y        = 470;
    localparam int LOSE_HOLD      = 4;
    localparam int RESPAWN_FRAMES = 3;

    // Expected output word: {state[1:0], lose, ball_rst, in_play}
    localparam logic [4:0] E_IDLE = 5'b00_0_1_0;
    localparam logic [4:0] E_PLAY = 5'b01_0_0_1;
    localparam logic [4:0] E_MISS = 5'b10_1_1_0;
    localparam logic [4:0] E_RESP = 5'b11_0_1_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [9:0] ball_y;
    logic       launch;
    logic       lose;
    logic       ball_rst;
    logic       in_play;
    logic [1:0] state;

    int checks    = 0;
    int errors    = 0;
    int lose_rises = 0;
    int exp_rises  = 0;
    logic prev_lose = 1'b0;

    logic [4:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        logic       launch;
        logic       ft;
        logic [9:0] y;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[18];

    pinball_round_ctrl #(
        .FLOOR_Y(FLOOR_Y),
        .LOSE_HOLD(LOSE_HOLD),
        .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .ball_y(ball_y),
        .launch(launch),
        .lose(lose),
        .ball_rst(ball_rst),
        .in_play(in_play),
        .state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lose === 1'b1 && prev_lose === 1'b0) lose_rises <= lose_rises + 1;
        prev_lose <= lose;
    end

    // driver: apply one cycle of inputs, queue the expected result, compare after the edge
    task automatic cyc(input logic r, input logic l, input logic f, input logic [9:0] y,
                       input logic [4:0] exp, input string nm);
        logic [4:0] got;
        logic [4:0] want;
        rst_n      = r;
        launch     = l;
        frame_tick = f;
        ball_y     = y;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = {state, lose, ball_rst, in_play};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got state=%0d lose=%b ball_rst=%b in_play=%b, expected state=%0d lose=%b ball_rst=%b in_play=%b",
                     nm, got[4:3], got[2], got[1], got[0], want[4:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic set_vec(input int i, input logic r, input logic l, input logic f,
                           input logic [9:0] y, input logic [4:0] exp);
        vecs[i].rst_n  = r;
        vecs[i].launch = l;
        vecs[i].ft     = f;
        vecs[i].y      = y;
        vecs[i].exp    = exp;
    endtask

    initial begin
        logic       f;
        logic [9:0] y;

        // reset, launch, floor boundary, full pulse and respawn
        set_vec(0,  1'b0, 1'b0, 1'b0, 10'd0,    E_IDLE);
        set_vec(1,  1'b0, 1'b0, 1'b0, 10'd0,    E_IDLE);
        set_vec(2,  1'b1, 1'b0, 1'b0, 10'd0,    E_IDLE);
        set_vec(3,  1'b1, 1'b1, 1'b0, 10'd0,    E_IDLE);
        set_vec(4,  1'b1, 1'b1, 1'b0, 10'd0,    E_IDLE);
        set_vec(5,  1'b1, 1'b1, 1'b0, 10'd0,    E_PLAY);
        set_vec(6,  1'b1, 1'b0, 1'b1, 10'd469,  E_PLAY);
        set_vec(7,  1'b1, 1'b0, 1'b0, 10'd470,  E_PLAY);
        set_vec(8,  1'b1, 1'b0, 1'b0, 10'd1023, E_PLAY);
        set_vec(9,  1'b1, 1'b0, 1'b1, 10'd470,  E_MISS);
        set_vec(10, 1'b1, 1'b0, 1'b0, 10'd0,    E_MISS);
        set_vec(11, 1'b1, 1'b0, 1'b0, 10'd0,    E_MISS);
        set_vec(12, 1'b1, 1'b0, 1'b0, 10'd0,    E_MISS);
        set_vec(13, 1'b1, 1'b0, 1'b0, 10'd0,    E_RESP);
        set_vec(14, 1'b1, 1'b0, 1'b1, 10'd0,    E_RESP);
        set_vec(15, 1'b1, 1'b0, 1'b0, 10'd0,    E_RESP);
        set_vec(16, 1'b1, 1'b0, 1'b1, 10'd0,    E_RESP);
        set_vec(17, 1'b1, 1'b0, 1'b1, 10'd0,    E_IDLE);
        exp_rises++;

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].rst_n, vecs[i].launch, vecs[i].ft, vecs[i].y, vecs[i].exp,
                $sformatf("vec%0d", i));
        end

        // idle with launch low for 100 cycles; frame ticks have no effect
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), E_IDLE, "idle_hold");
        end

        // launch held throughout: play, miss with ticks during MISS, respawn, no relaunch
        cyc(1'b1, 1'b1, 1'b0, 10'd0, E_IDLE, "held_e1");
        cyc(1'b1, 1'b1, 1'b0, 10'd0, E_IDLE, "held_e2");
        cyc(1'b1, 1'b1, 1'b0, 10'd0, E_PLAY, "held_e3");
        for (int i = 0; i < 8; i++) begin
            f = 1'($urandom_range(0, 1));
            y = f ? 10'($urandom_range(0, FLOOR_Y - 1)) : 10'($urandom_range(0, 1023));
            cyc(1'b1, 1'b1, f, y, E_PLAY, "play_rand");
        end
        cyc(1'b1, 1'b1, 1'b1, 10'($urandom_range(FLOOR_Y, 1023)), E_MISS, "held_miss");
        exp_rises++;
        for (int i = 0; i < LOSE_HOLD - 1; i++) cyc(1'b1, 1'b1, 1'b1, 10'd0, E_MISS, "miss_tick_ign");
        cyc(1'b1, 1'b1, 1'b1, 10'd0, E_RESP, "miss_exit_tick");
        cyc(1'b1, 1'b1, 1'b1, 10'd0, E_RESP, "resp_tick1");
        cyc(1'b1, 1'b1, 1'b1, 10'd0, E_RESP, "resp_tick2");
        cyc(1'b1, 1'b1, 1'b1, 10'd0, E_IDLE, "resp_tick3");
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 10'd0, E_IDLE, "no_relaunch");
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 10'd0, E_IDLE, "release");

        // a press landing in MISS and one landing on the RESPAWN exit are both dropped
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_IDLE, "l2_e1");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_IDLE, "l2_e2");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_PLAY, "l2_e3");
        cyc(1'b1, 1'b0, 1'b1, 10'd470, E_MISS, "l2_miss");
        exp_rises++;
        cyc(1'b1, 1'b0, 1'b0, 10'd0,   E_MISS, "l2_miss2");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_MISS, "l2_press_miss3");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_MISS, "l2_press_miss4");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_RESP, "l2_rise_at_exit");
        cyc(1'b1, 1'b0, 1'b0, 10'd0,   E_RESP, "l2_release");
        cyc(1'b1, 1'b1, 1'b1, 10'd0,   E_RESP, "l2_tick1");
        cyc(1'b1, 1'b1, 1'b1, 10'd0,   E_RESP, "l2_tick2");
        cyc(1'b1, 1'b1, 1'b1, 10'd0,   E_IDLE, "l2_tick3_rise");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 10'd0, E_IDLE, "rise_dropped");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 10'd0, E_IDLE, "release2");

        // reset on the second cycle of lose truncates the pulse
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_IDLE, "l3_e1");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_IDLE, "l3_e2");
        cyc(1'b1, 1'b1, 1'b0, 10'd0,   E_PLAY, "l3_e3");
        cyc(1'b1, 1'b0, 1'b1, 10'd470, E_MISS, "l3_miss");
        exp_rises++;
        cyc(1'b1, 1'b0, 1'b0, 10'd0,   E_MISS, "l3_miss2");
        cyc(1'b0, 1'b0, 1'b0, 10'd0,   E_IDLE, "reset_mid_miss");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 10'd0, E_IDLE, "post_reset");

        checks++;
        if (lose_rises != exp_rises) begin
            errors++;
            $display("FAIL lose_rises: got %0d, expected %0d", lose_rises, exp_rises);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
